// File: rtl/mod_cnt_pkg.sv
// rtl/mod_cnt_pkg.sv - shared direction constants and load clamp helper for modulus counters
package mod_cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max_v);
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - up/down modulus counter with shadowed runtime-programmable terminal value
module prog_mod_counter
  import mod_cnt_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int unsigned DEFAULT_MAX = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             max_wr,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] max_cur,
  output logic             tc
);

  localparam logic [WIDTH-1:0] DEF_MAX = WIDTH'(DEFAULT_MAX);

  logic [WIDTH-1:0] max_shadow;
  logic [WIDTH-1:0] max_next;
  logic [WIDTH-1:0] count_next;
  logic             pend;
  logic             at_term;
  logic             boundary;

  assign at_term  = (up_dn == CNT_UP) ? (count == max_cur) : (count == '0);
  assign tc       = en & at_term;
  assign boundary = load | tc;

  // A same-edge write beats an older pending value at the boundary.
  always_comb begin
    max_next = max_cur;
    if (boundary) begin
      if (max_wr)
        max_next = max_val;
      else if (pend)
        max_next = max_shadow;
    end
  end

  always_comb begin
    count_next = count;
    if (load)
      count_next = WIDTH'(clamp_to_max(32'(load_val), 32'(max_next)));
    else if (en) begin
      if (up_dn == CNT_UP)
        count_next = (count == max_cur) ? '0 : count + WIDTH'(1);
      else
        count_next = (count == '0) ? max_next : count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      max_cur    <= DEF_MAX;
      max_shadow <= DEF_MAX;
      pend       <= 1'b0;
    end else begin
      count   <= count_next;
      max_cur <= max_next;
      if (max_wr)
        max_shadow <= max_val;
      pend <= boundary ? 1'b0 : (pend | max_wr);
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - scoreboard bench for prog_mod_counter plus a two-stage BCD cascade
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, max_wr;
  logic [7:0] load_val, max_val;
  logic [7:0] count, max_cur;
  logic       tc;

  logic       crst, cen, cup;
  logic [3:0] lo_count, lo_max, hi_count, hi_max;
  logic       lo_tc, hi_tc;

  int n_checks = 0;
  int n_fail   = 0;
  bit inv_on   = 1'b0;

  typedef struct {
    logic [7:0] c;
    logic [7:0] m;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_count, m_max, m_shadow;
  logic       m_pend;

  always #5 clk = ~clk;

  prog_mod_counter #(.WIDTH(8), .DEFAULT_MAX(5)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .max_wr(max_wr), .max_val(max_val), .count(count), .max_cur(max_cur), .tc(tc)
  );

  prog_mod_counter #(.WIDTH(4), .DEFAULT_MAX(9)) lo (
    .clk(clk), .rst(crst), .en(cen), .up_dn(cup), .load(1'b0), .load_val(4'd0),
    .max_wr(1'b0), .max_val(4'd0), .count(lo_count), .max_cur(lo_max), .tc(lo_tc)
  );

  prog_mod_counter #(.WIDTH(4), .DEFAULT_MAX(9)) hi (
    .clk(clk), .rst(crst), .en(lo_tc), .up_dn(cup), .load(1'b0), .load_val(4'd0),
    .max_wr(1'b0), .max_val(4'd0), .count(hi_count), .max_cur(hi_max), .tc(hi_tc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Every-cycle properties of the main counter.
  always @(negedge clk) begin
    if (inv_on) begin
      check("inv_count_le_max", 32'(count <= max_cur), 1);
      check("tc_equation", tc, en & (up_dn ? (count == max_cur) : (count == 8'd0)));
    end
  end

  // One clock: check tc against the model, push the model's next state, compare after the edge.
  task automatic step();
    logic       exp_tc, bnd, n_pend;
    logic [7:0] n_max, n_count;
    exp_t       e;
    @(negedge clk);
    exp_tc = en && (up_dn ? (m_count == m_max) : (m_count == 8'd0));
    if (!rst) check("tc_model", tc, exp_tc);
    if (rst) begin
      n_count = 0; n_max = 5; m_shadow = 5; n_pend = 0;
    end else begin
      bnd   = load || exp_tc;
      n_max = m_max;
      if (bnd && max_wr)      n_max = max_val;
      else if (bnd && m_pend) n_max = m_shadow;
      n_pend = bnd ? 1'b0 : (m_pend || max_wr);
      if (max_wr) m_shadow = max_val;
      n_count = m_count;
      if (load)            n_count = (load_val > n_max) ? n_max : load_val;
      else if (en && up_dn)  n_count = (m_count == m_max) ? 8'd0 : m_count + 8'd1;
      else if (en && !up_dn) n_count = (m_count == 8'd0) ? n_max : m_count - 8'd1;
    end
    m_count = n_count; m_max = n_max; m_pend = n_pend;
    e.c = n_count; e.m = n_max;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_count", count, e.c);
    check("sb_max_cur", max_cur, e.m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    rst = 1; en = 0; up_dn = 1; load = 0; load_val = 0; max_wr = 0; max_val = 0;
    crst = 1; cen = 0; cup = 1;
    m_count = 0; m_max = 5; m_shadow = 5; m_pend = 0;
    step();
    check("rst_count", count, 0);
    check("rst_max_cur", max_cur, 5);
    inv_on = 1'b1;

    rst = 0; en = 1; up_dn = 1;
    for (int i = 0; i < 14; i++) begin
      check("seq_count", count, i % 6);
      check("seq_tc", tc, 32'((i % 6) == 5));
      check("seq_max", max_cur, 5);
      step();
    end

    max_wr = 1; max_val = 9;
    step();
    max_wr = 0;
    check("shadow_hold", max_cur, 5);
    for (int i = 0; i < 3; i++) step();
    check("shadow_wrap_count", count, 0);
    check("shadow_applied", max_cur, 9);
    for (int i = 0; i < 9; i++) step();
    check("shadow_at9", count, 9);
    step();
    check("shadow_wrap9", count, 0);

    en = 0; load = 1; load_val = 1; max_wr = 1; max_val = 5;
    step();
    check("setup_count", count, 1);
    check("setup_max", max_cur, 5);
    load = 0; en = 1; up_dn = 0; max_wr = 1; max_val = 3;
    step();
    max_wr = 0;
    check("dn_count0", count, 0);
    check("dn_max_pending", max_cur, 5);
    step();
    check("dn_wrap_count", count, 3);
    check("dn_wrap_max", max_cur, 3);

    en = 0; load = 1; load_val = 0; max_wr = 1; max_val = 5;
    step();
    max_wr = 0; en = 1; up_dn = 1; load_val = 200;
    step();
    check("load_clamp", count, 5);
    load_val = 3; rst = 1;
    step();
    check("rst_beats_load", count, 0);
    check("rst_beats_load_max", max_cur, 5);

    rst = 0; load = 0; en = 1; up_dn = 1; max_wr = 1; max_val = 0;
    step();
    max_wr = 0;
    for (int i = 0; i < 5; i++) step();
    check("div1_max", max_cur, 0);
    for (int i = 0; i < 4; i++) begin
      up_dn = (i < 2);
      check("div1_count", count, 0);
      check("div1_tc", tc, 1);
      step();
    end
    en = 0;
    #1;
    check("div1_tc_off", tc, 0);
    step();

    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom_range(0, 20));
      max_wr   = ($urandom_range(0, 7) == 0);
      max_val  = 8'($urandom_range(0, 15));
      step();
    end
    rst = 0; en = 0; load = 0; max_wr = 0;

    @(posedge clk); #1;
    crst = 0; cen = 1; cup = 1;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      check("bcd_value", 32'(hi_count) * 10 + 32'(lo_count), i);
      if (hi_tc) begin
        hits++;
        check("hi_tc_lo9", lo_count, 9);
      end
      @(posedge clk); #1;
    end
    check("bcd_rollover", 32'(hi_count) * 10 + 32'(lo_count), 0);
    check("hi_tc_once", hits, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
